// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch FSM states and NOP encoding for the 16-bit CPU front end
package cpu_pkg;
  localparam int ADDR_W       = 16;
  localparam int REG_W        = 4;
  localparam int DRAIN_CYCLES = 3;
  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between EX load and ID sources
module hazard_detect #(
  parameter int REG_W = 4
) (
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             stall_o
);
  // Register 0 is hardwired zero, so a load into it never creates a dependency.
  assign stall_o = ex_mem_read_i && (ex_rd_i != '0) &&
                   ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC update, IF/ID and ID/EX flush/stall control for the fetch/decode front end
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = cpu_pkg::ADDR_W,
  parameter int REG_W        = cpu_pkg::REG_W,
  parameter int DRAIN_CYCLES = cpu_pkg::DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              hlt,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic              imem_rdy,
  output logic              imem_rd_en,
  output logic              pc_we,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              halted
);
  localparam int DCW = $clog2(DRAIN_CYCLES) + 1;

  fetch_state_t   state_q, state_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           load_use;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .stall_o       (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    imem_rd_en  = 1'b0;
    pc_we       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      drain_d    = '0;
    end else begin
      unique case (state_q)
        RUN, MEMWAIT: begin
          imem_rd_en = 1'b1;
          if (branch_taken) begin
            // Resolved branch outranks everything younger, including an in-flight fetch.
            pc_we       = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = branch_addr;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            state_d     = RUN;
          end else if (jump) begin
            pc_we       = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = jump_addr;
            ifid_flush  = 1'b1;
            state_d     = RUN;
          end else if (hlt) begin
            imem_rd_en = 1'b0;
            drain_d    = DCW'(DRAIN_CYCLES - 1);
            state_d    = DRAIN;
          end else if (load_use) begin
            // IF/ID is held, not flushed, so the dependent instruction survives a memory wait too.
            idex_flush = 1'b1;
          end else if (!imem_rdy) begin
            ifid_flush = 1'b1;
            state_d    = MEMWAIT;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            state_d = RUN;
          end
        end
        DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (branch_taken) begin
            pc_we       = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = branch_addr;
            state_d     = RUN;
          end else if (drain_q == '0) begin
            state_d = HALTED;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with directed and random stimulus
module tb_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        branch_taken, jump, hlt, ex_mem_read, id_uses_rt, imem_rdy;
  logic [15:0] branch_addr, jump_addr;
  logic [3:0]  ex_rd, id_rs, id_rt;
  logic        imem_rd_en, pc_we, pc_redirect, ifid_we, ifid_flush, idex_flush, halted;
  logic [15:0] redirect_pc;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .hlt          (hlt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .imem_rdy     (imem_rdy),
    .imem_rd_en   (imem_rd_en),
    .pc_we        (pc_we),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .halted       (halted)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        imem_rd_en;
    logic        pc_we;
    logic        pc_redirect;
    logic [15:0] redirect_pc;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference: 0 = fetching, 1 = draining toward halt, 2 = halted.
  int m_mode = 0;
  int m_drain_left = 0;

  task automatic cyc(input string tag, input logic r, input logic bt, input logic [15:0] ba,
                     input logic j, input logic [15:0] ja, input logic h, input logic mr,
                     input logic [3:0] erd, input logic [3:0] rs, input logic [3:0] rt,
                     input logic urt, input logic rdy);
    exp_t e;
    logic lu;
    rst = r; branch_taken = bt; branch_addr = ba; jump = j; jump_addr = ja; hlt = h;
    ex_mem_read = mr; ex_rd = erd; id_rs = rs; id_rt = rt; id_uses_rt = urt; imem_rdy = rdy;
    lu = mr && (erd != 4'd0) && ((erd == rs) || (urt && (erd == rt)));
    e = '0;
    if (r) begin
      e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      m_mode = 0;
    end else if (m_mode == 2) begin
      e.halted = 1'b1;
    end else if (m_mode == 1) begin
      e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      if (bt) begin
        e.pc_we = 1'b1; e.pc_redirect = 1'b1; e.redirect_pc = ba;
        m_mode = 0;
      end else begin
        m_drain_left = m_drain_left - 1;
        if (m_drain_left == 0) m_mode = 2;
      end
    end else begin
      e.imem_rd_en = 1'b1;
      if (bt) begin
        e.pc_we = 1'b1; e.pc_redirect = 1'b1; e.redirect_pc = ba;
        e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      end else if (j) begin
        e.pc_we = 1'b1; e.pc_redirect = 1'b1; e.redirect_pc = ja; e.ifid_flush = 1'b1;
      end else if (h) begin
        e.imem_rd_en = 1'b0;
        m_mode = 1; m_drain_left = DRAIN_CYCLES;
      end else if (lu) begin
        e.idex_flush = 1'b1;
      end else if (!rdy) begin
        e.ifid_flush = 1'b1;
      end else begin
        e.pc_we = 1'b1; e.ifid_we = 1'b1;
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t  e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {imem_rd_en, pc_we, pc_redirect, redirect_pc, ifid_we, ifid_flush, idex_flush, halted};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got rd_en=%b pc_we=%b redir=%b rpc=%h ifid_we=%b ifid_fl=%b idex_fl=%b halted=%b, expected rd_en=%b pc_we=%b redir=%b rpc=%h ifid_we=%b ifid_fl=%b idex_fl=%b halted=%b",
                 t, a.imem_rd_en, a.pc_we, a.pc_redirect, a.redirect_pc, a.ifid_we, a.ifid_flush,
                 a.idex_flush, a.halted, e.imem_rd_en, e.pc_we, e.pc_redirect, e.redirect_pc,
                 e.ifid_we, e.ifid_flush, e.idex_flush, e.halted);
      end
    end
  end

  initial begin
    cyc("reset0", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    cyc("reset1", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle("run");
    cyc("jump", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    cyc("branch_prio", 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0009, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    idle("after_branch");
    cyc("load_use_rs", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd5, 4'd5, 4'd1, 1'b0, 1'b1);
    cyc("load_r0", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    cyc("load_use_rt", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd7, 4'd2, 4'd7, 1'b1, 1'b1);
    cyc("load_rt_unused", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd7, 4'd2, 4'd7, 1'b0, 1'b1);
    cyc("load_use_nordy", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("memwait", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    idle("memwait_exit");
    cyc("hlt", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle("drain");
    for (int i = 0; i < 10; i++)
      cyc("halted_sticky", 1'b0, 1'b1, 16'h00aa, 1'b1, 16'h0bb, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, (i % 2) == 0);
    cyc("reset_from_halt", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    idle("run_after_reset");
    cyc("hlt2", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    idle("drain_c1");
    cyc("drain_branch", 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    idle("run_after_cancel");
    cyc("memwait_enter", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc("reset_in_memwait", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    idle("run_after_reset2");
    for (int i = 0; i < 600; i++) begin
      cyc("random", $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, 16'($urandom),
          $urandom_range(0, 9) == 0, 16'($urandom), $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
          4'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 4) != 0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
